apb_gpio_slave_if: RTL and testbench
====================================

# apb_gpio_slave_if

APB3 slave front-end for the GPIO core, sitting directly upstream of the GPIO register file. Converts APB transfers from the system bus into the register file's single-cycle write strobe, address and write data, and returns its combinational readback on PRDATA. Adds programmable wait states, address-range and alignment checking with PSLVERR, and abort handling for malformed transfers.

## Interface
- WAIT_STATES, default 0: extra ACCESS cycles inserted before PREADY (0–15).
- LAST_OFFSET, default 32'h24: highest legal word offset (RGPIO_NEC).
- sys_clk  in  1  system clock, all logic rising-edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- PSEL  in  1  APB slave select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address, GPIO-local offset.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, valid only with PREADY.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error response, valid only with PREADY.
- gpio_we  out  1  one-cycle write strobe to register file.
- gpio_addr  out  32  latched register offset to register file.
- gpio_wdata  out  32  latched write data (drives register file gpio_dat_i).
- gpio_rdata  in  32  register file readback (from gpio_dat_o), combinational on gpio_addr.

## Operation
- FSM states: IDLE, ACCESS. 4-bit wait counter cnt.
- IDLE: on edge with PSEL=1, PENABLE=0 (SETUP): latch PADDR→gpio_addr, PWDATA→gpio_wdata, PWRITE→wr_q; compute err_q = (PADDR[1:0]≠0) | (PADDR>LAST_OFFSET); cnt←WAIT_STATES; go ACCESS.
- IDLE with PSEL=1, PENABLE=1 (no preceding SETUP): ignored, stay IDLE, PREADY=0.
- ACCESS, PSEL=0: abort, go IDLE, no write, no response.
- ACCESS, PSEL=1, cnt≠0: cnt decrements, PREADY=0.
- ACCESS, PSEL=1, PENABLE=1, cnt=0: completing cycle, go IDLE.
- PREADY = (state=ACCESS) & PSEL & PENABLE & (cnt=0), combinational.
- PSLVERR = PREADY & err_q.
- gpio_we = PREADY & wr_q & ~err_q; errored writes never reach the register file.
- PRDATA = gpio_rdata when PREADY & ~wr_q & ~err_q, else 32'h0.
- gpio_addr/gpio_wdata hold last latched value between transfers.
- Offset 0x1C (INTS) is legal for read and write; write side effects belong to the register file.

## Timing
- Reset: state IDLE, cnt 0, gpio_addr 0, gpio_wdata 0, wr_q 0, err_q 0; PREADY, PSLVERR, gpio_we 0; PRDATA 0.
- WAIT_STATES=0: SETUP cycle T0, ACCESS T1 with PREADY=1; register file updates on the T1→T2 edge.
- WAIT_STATES=N: PREADY in cycle T1+N; total transfer N+2 cycles.
- Read data: gpio_addr valid from T1, so gpio_rdata settled within ACCESS; no extra latency.
- Back-to-back: SETUP may follow the completing cycle directly; one transfer every 2+N cycles.
- sys_rst mid-transfer: immediate return to IDLE, gpio_we deasserted asynchronously, partial write never committed.
- gpio_we is high at most one cycle per transfer.

## Structure
- Shared package gpio_pkg: register offset constants (IN 0x00 … NEC 0x24), LAST_OFFSET default, FSM state enum; the register file uses the same offsets.
- No sub-module; FSM, counter and error decode fit in one module.

## Test plan
- Write 0xA5A5_0F0F to 0x04, WAIT_STATES=0 -> PREADY in 2nd cycle, gpio_we one cycle with gpio_addr=0x04, gpio_wdata=0xA5A5_0F0F, PSLVERR=0.
- Read 0x08 with gpio_rdata=0x0000_00FF, WAIT_STATES=3 -> PREADY exactly 5th cycle, PRDATA=0x0000_00FF, PRDATA=0 in other cycles.
- Write 0x28 and write 0x06 -> PREADY=1, PSLVERR=1, gpio_we stays 0; read 0x28 -> PRDATA=0, PSLVERR=1.
- PSEL dropped in wait state (WAIT_STATES=2) during write to 0x0C -> no gpio_we, FSM IDLE, next transfer to 0x0C completes normally.
- Back-to-back writes 0x04, 0x08, then read 0x04 -> gpio_we pulses in cycles 2 and 4, read returns value written.
- sys_rst asserted during ACCESS of write -> gpio_we, PREADY 0 immediately, gpio_addr=0, no register update.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: register offsets, the APB front-end state type and
// the offset legality rule used by the bus slave.
package gpio_pkg;

    localparam logic [31:0] GPIO_RGPIO_IN    = 32'h00;
    localparam logic [31:0] GPIO_RGPIO_OUT   = 32'h04;
    localparam logic [31:0] GPIO_RGPIO_OE    = 32'h08;
    localparam logic [31:0] GPIO_RGPIO_INTE  = 32'h0C;
    localparam logic [31:0] GPIO_RGPIO_PTRIG = 32'h10;
    localparam logic [31:0] GPIO_RGPIO_AUX   = 32'h14;
    localparam logic [31:0] GPIO_RGPIO_CTRL  = 32'h18;
    localparam logic [31:0] GPIO_RGPIO_INTS  = 32'h1C;
    localparam logic [31:0] GPIO_RGPIO_ECLK  = 32'h20;
    localparam logic [31:0] GPIO_RGPIO_NEC   = 32'h24;

    localparam logic [31:0] GPIO_LAST_OFFSET = GPIO_RGPIO_NEC;

    typedef enum logic {
        APB_IDLE,
        APB_ACCESS
    } apb_state_e;

    // Word offsets only, and nothing past the last implemented register.
    function automatic logic offset_err(input logic [31:0] addr, input logic [31:0] last);
        return (addr[1:0] != 2'b00) || (addr > last);
    endfunction

endpackage

// File: rtl/apb_gpio_slave_if_if.sv
// APB3 bus bundle between the system interconnect and the GPIO slave front-end.
interface apb_gpio_slave_if_if;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_gpio_slave_if.sv
// APB3 slave front-end for the GPIO register file: wait states, offset checking
// with PSLVERR, abort on dropped PSEL, single-cycle write strobe.
module apb_gpio_slave_if
    import gpio_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] LAST_OFFSET = GPIO_LAST_OFFSET
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    apb_gpio_slave_if_if.slave apb,
    output logic               gpio_we,
    output logic [31:0]        gpio_addr,
    output logic [31:0]        gpio_wdata,
    input  logic [31:0]        gpio_rdata
);

    apb_state_e state;
    logic [3:0] cnt;
    logic       wr_q;
    logic       err_q;
    logic       ready;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= APB_IDLE;
            cnt        <= '0;
            gpio_addr  <= '0;
            gpio_wdata <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                APB_IDLE: begin
                    // An access phase without a preceding setup is ignored.
                    if (apb.PSEL && !apb.PENABLE) begin
                        gpio_addr  <= apb.PADDR;
                        gpio_wdata <= apb.PWDATA;
                        wr_q       <= apb.PWRITE;
                        err_q      <= offset_err(apb.PADDR, LAST_OFFSET);
                        cnt        <= 4'(WAIT_STATES);
                        state      <= APB_ACCESS;
                    end
                end
                APB_ACCESS: begin
                    if (!apb.PSEL) begin
                        state <= APB_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else if (apb.PENABLE) begin
                        state <= APB_IDLE;
                    end
                end
                default: state <= APB_IDLE;
            endcase
        end
    end

    // Outputs are decoded from state so reset clears them without waiting for a clock.
    assign ready       = (state == APB_ACCESS) && apb.PSEL && apb.PENABLE && (cnt == '0);
    assign apb.PREADY  = ready;
    assign apb.PSLVERR = ready && err_q;
    assign apb.PRDATA  = (ready && !wr_q && !err_q) ? gpio_rdata : '0;
    assign gpio_we     = ready && wr_q && !err_q;

endmodule

// File: tb/tb_apb_gpio_slave_if.sv
// Bench for apb_gpio_slave_if: three instances with 0/3/2 wait states against a
// behavioural register-file model, directed cases followed by random transfers.
module tb_apb_gpio_slave_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    int          sel;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        rf_clr;

    logic [31:0] rf [16];
    logic [31:0] exp_mem [16];

    logic        pready_a [3];
    logic        pslverr_a [3];
    logic        we_a [3];
    logic [31:0] prdata_a [3];
    logic [31:0] gaddr_a [3];
    logic [31:0] gwdata_a [3];
    logic [31:0] grdata_a [3];

    logic        pready_s, pslverr_s, we_s;
    logic [31:0] prdata_s, gaddr_s, gwdata_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_gpio_slave_if_if bus0 ();
    apb_gpio_slave_if_if bus1 ();
    apb_gpio_slave_if_if bus2 ();

    assign bus0.PSEL = psel && (sel == 0);
    assign bus1.PSEL = psel && (sel == 1);
    assign bus2.PSEL = psel && (sel == 2);
    assign bus0.PENABLE = penable; assign bus1.PENABLE = penable; assign bus2.PENABLE = penable;
    assign bus0.PWRITE  = pwrite;  assign bus1.PWRITE  = pwrite;  assign bus2.PWRITE  = pwrite;
    assign bus0.PADDR   = paddr;   assign bus1.PADDR   = paddr;   assign bus2.PADDR   = paddr;
    assign bus0.PWDATA  = pwdata;  assign bus1.PWDATA  = pwdata;  assign bus2.PWDATA  = pwdata;

    assign pready_a[0] = bus0.PREADY;  assign pready_a[1] = bus1.PREADY;  assign pready_a[2] = bus2.PREADY;
    assign pslverr_a[0] = bus0.PSLVERR; assign pslverr_a[1] = bus1.PSLVERR; assign pslverr_a[2] = bus2.PSLVERR;
    assign prdata_a[0] = bus0.PRDATA;  assign prdata_a[1] = bus1.PRDATA;  assign prdata_a[2] = bus2.PRDATA;

    apb_gpio_slave_if #(.WAIT_STATES(0)) dut0 (
        .sys_clk(clk), .sys_rst(rst), .apb(bus0),
        .gpio_we(we_a[0]), .gpio_addr(gaddr_a[0]), .gpio_wdata(gwdata_a[0]), .gpio_rdata(grdata_a[0])
    );
    apb_gpio_slave_if #(.WAIT_STATES(3)) dut1 (
        .sys_clk(clk), .sys_rst(rst), .apb(bus1),
        .gpio_we(we_a[1]), .gpio_addr(gaddr_a[1]), .gpio_wdata(gwdata_a[1]), .gpio_rdata(grdata_a[1])
    );
    apb_gpio_slave_if #(.WAIT_STATES(2)) dut2 (
        .sys_clk(clk), .sys_rst(rst), .apb(bus2),
        .gpio_we(we_a[2]), .gpio_addr(gaddr_a[2]), .gpio_wdata(gwdata_a[2]), .gpio_rdata(grdata_a[2])
    );

    // Behavioural register file shared by all instances (only one is selected at a time).
    assign grdata_a[0] = rf[gaddr_a[0][5:2]];
    assign grdata_a[1] = rf[gaddr_a[1][5:2]];
    assign grdata_a[2] = rf[gaddr_a[2][5:2]];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            if (we_a[0]) rf[gaddr_a[0][5:2]] <= gwdata_a[0];
            if (we_a[1]) rf[gaddr_a[1][5:2]] <= gwdata_a[1];
            if (we_a[2]) rf[gaddr_a[2][5:2]] <= gwdata_a[2];
        end
    end

    assign pready_s  = pready_a[sel];
    assign pslverr_s = pslverr_a[sel];
    assign we_s      = we_a[sel];
    assign prdata_s  = prdata_a[sel];
    assign gaddr_s   = gaddr_a[sel];
    assign gwdata_s  = gwdata_a[sel];

    function automatic int unsigned ws_of(input int k);
        case (k)
            0: return 0;
            1: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic model_err(input logic [31:0] addr);
        return ((addr % 4) != 0) || (addr > 36);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    // Full APB transfer starting right after a rising edge; returns right after the
    // edge that ends the completing cycle, so calls can be chained back-to-back.
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input string tag);
        int unsigned n;
        int unsigned we_n;
        logic        done;
        logic        e;
        logic [31:0] exp_rd;
        e      = model_err(addr);
        exp_rd = (!wr && !e) ? exp_mem[addr[5:2]] : 32'h0;
        sel = k; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(negedge clk);
        we_n = we_s ? 1 : 0;
        check({tag, " setup_pready"}, 32'(pready_s), 32'h0);
        @(posedge clk) #1;
        penable = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < 40) begin
            n++;
            @(negedge clk);
            if (we_s) we_n++;
            if (pready_s) begin
                done = 1'b1;
                check({tag, " pslverr"}, 32'(pslverr_s), 32'(e));
                check({tag, " prdata"}, prdata_s, exp_rd);
                check({tag, " gpio_addr"}, gaddr_s, addr);
                check({tag, " gpio_wdata"}, gwdata_s, data);
            end else begin
                check({tag, " wait_prdata"}, prdata_s, 32'h0);
                @(posedge clk) #1;
            end
        end
        check({tag, " pready_cycle"}, n, ws_of(k) + 1);
        check({tag, " we_pulses"}, we_n, (wr && !e) ? 32'd1 : 32'd0);
        if (wr && !e) exp_mem[addr[5:2]] = data;
        @(posedge clk) #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        int          c0;
        int          k;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;

        rst = 1'b1; rf_clr = 1'b1; sel = 0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check("rst pready", 32'(pready_a[i]), 32'h0);
            check("rst pslverr", 32'(pslverr_a[i]), 32'h0);
            check("rst gpio_we", 32'(we_a[i]), 32'h0);
            check("rst prdata", prdata_a[i], 32'h0);
            check("rst gpio_addr", gaddr_a[i], 32'h0);
            check("rst gpio_wdata", gwdata_a[i], 32'h0);
        end
        rst = 1'b0; rf_clr = 1'b0;
        @(posedge clk) #1;

        // Access phase without setup must be ignored.
        sel = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nosetup pready", 32'(pready_s), 32'h0);
            check("nosetup gpio_we", 32'(we_s), 32'h0);
            @(posedge clk) #1;
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk) #1;

        xfer(0, 1'b1, 32'h04, 32'hA5A5_0F0F, "wr04_ws0");
        @(posedge clk) #1;
        xfer(0, 1'b1, 32'h08, 32'h0000_00FF, "wr08_ws0");
        xfer(1, 1'b0, 32'h08, 32'h0, "rd08_ws3");
        xfer(0, 1'b1, 32'h28, 32'hDEAD_BEEF, "wr28_err");
        xfer(0, 1'b1, 32'h06, 32'hCAFE_F00D, "wr06_err");
        xfer(1, 1'b0, 32'h28, 32'h0, "rd28_err");
        xfer(2, 1'b1, 32'h1C, 32'h0000_0003, "wr1c_ints");
        xfer(2, 1'b0, 32'h24, 32'h0, "rd24_last");

        // Abort: PSEL dropped during a wait state.
        sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h7777_0000;
        @(posedge clk) #1;
        penable = 1'b1;
        @(negedge clk);
        check("abort wait_pready", 32'(pready_s), 32'h0);
        @(posedge clk) #1;
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort gpio_we", 32'(we_s), 32'h0);
            check("abort pready", 32'(pready_s), 32'h0);
            @(posedge clk) #1;
        end
        check("abort rf_untouched", rf[3], exp_mem[3]);
        xfer(2, 1'b1, 32'h0C, 32'h0000_5555, "wr0c_after_abort");

        // Back-to-back: one transfer every two cycles with WAIT_STATES=0.
        @(posedge clk) #1;
        c0 = cyc;
        xfer(0, 1'b1, 32'h04, 32'h1111_2222, "b2b_wr04");
        xfer(0, 1'b1, 32'h08, 32'h3333_4444, "b2b_wr08");
        xfer(0, 1'b0, 32'h04, 32'h0, "b2b_rd04");
        check("b2b cycles", 32'(cyc - c0), 32'd6);

        // Reset asserted in the ACCESS cycle of a write.
        sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hBAD0_BAD0;
        @(posedge clk) #1;
        penable = 1'b1;
        @(negedge clk);
        check("rstmid we_before", 32'(we_s), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rstmid gpio_we", 32'(we_s), 32'h0);
        check("rstmid pready", 32'(pready_s), 32'h0);
        check("rstmid gpio_addr", gaddr_s, 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk) #1;
        rst = 1'b0;
        @(posedge clk) #1;
        check("rstmid rf_untouched", rf[4], exp_mem[4]);
        xfer(0, 1'b0, 32'h10, 32'h0, "rd10_after_rst");

        for (int i = 0; i < 40; i++) begin
            k    = int'($urandom_range(0, 2));
            wr   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 11)) * 32'd4;
            if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
            data = $urandom;
            xfer(k, wr, addr, data, "random");
            if ($urandom_range(0, 1) == 1) @(posedge clk) #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
